instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
// - Requester side of the combinational instruction memory: owns the PC, drives the word-indexed fetch address and captures returned instructions.
// - Captured instructions sit in a small prefetch FIFO and go to the decode stage over a valid/ready handshake.
// - Handles branch redirect: flush plus PC reload.
// - Sits between the PC/IF stage boundary and the IF/ID pipeline register.
// PARAMETERS
// - FIFO_DEPTH  2             prefetch entries, power of 2, >= 2
// - RESET_PC    32'h0000_0000 byte address loaded into the PC on reset
// PORTS
// - clk           in   1   single clock; all state updates on the rising edge
// - rst           in   1   synchronous, active-high reset
// - imem_adr      out  32  word index to instruction memory = {2'b00, pc[31:2]}
// - imem_inst     in   32  instruction returned combinationally for imem_adr
// - branch_taken  in   1   redirect request from EX (already condition-qualified)
// - branch_addr   in   32  byte target of the redirect; bits [1:0] ignored
// - id_ready      in   1   decode accepts the head entry this cycle (0 = hazard freeze)
// - if_valid      out  1   head entry valid
// - if_inst       out  32  head instruction; 32'h0 when if_valid=0
// - if_pc         out  32  head PC+4 (byte); 32'h0 when if_valid=0
// - fifo_count    out  $clog2(FIFO_DEPTH)+1  occupancy, for debug
// BEHAVIOUR
// - Reset (rst=1 at edge):
//   - pc <= RESET_PC; FIFO emptied; if_valid=0; if_inst=0; if_pc=0; fifo_count=0.
//   - Reset overrides everything, including a fetch or branch in flight.
// - Definitions:
//   - pop  = if_valid & id_ready
//   - full = (count == FIFO_DEPTH)
//   - push = ~branch_taken & (~full | pop)
// - Push: write {pc+4, imem_inst} at the tail; pc <= pc+4, modulo 2^32.
//   - 0xFFFF_FFFC wraps to 0.
// - No push: pc holds and imem_adr is stable.
// - Pop: the head advances.
//   - Simultaneous push and pop keeps count unchanged, including when full, so throughput is 1 instruction/cycle.
// - Latency: an instruction fetched in cycle N appears at the head with if_valid=1 in cycle N+1. There is no combinational bypass.
// - Branch (branch_taken=1, rst=0) has priority over push and pop:
//   - FIFO flushed, count <= 0;
//   - pc <= {branch_addr[31:2], 2'b00};
//   - no push that cycle; if_valid=0 the next cycle;
//   - the first target instruction is valid 2 cycles after branch_taken.
//   - A concurrent pop is still treated as consumed by decode; decode squashes it itself.
// - Back-to-back branches: the last one wins, and each one flushes.
// - Freeze: id_ready=0 with the FIFO full stalls the PC. Entries and outputs hold unchanged, with no loss or duplication.
// - Empty FIFO with id_ready=1: if_valid=0 and no pop.
// - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is one bit wider so full and empty can be told apart.
// STRUCTURE
// - Shared package:
//   - INST_W=32
//   - RESET_PC default
//   - NOP_INST=32'h0
//   - typedef fetch_entry_t {pc_plus4[31:0], inst[31:0]}
// - One sub-module fetch_fifo: sync FIFO with flush, push/pop, registered head, count.
// - Top level: PC register, push/branch control, imem_adr formation.
// TESTING
// - Reset, then stream with id_ready=1:
//   - imem_adr steps 0,1,2,...;
//   - if_pc sequence 4,8,12 from cycle 1;
//   - if_valid stays high after the first fetch.
// - Freeze: hold id_ready=0 for 5 cycles from PC=0x10.
//   - fifo_count reaches 2 and pc stops at 0x18.
//   - Release: if_pc delivers 0x14, 0x18, 0x1C in order, with no gaps or duplicates.
// - Branch: branch_taken=1 with branch_addr=0x93 while the FIFO holds 2 entries.
//   - Next cycle: if_valid=0, count=0, imem_adr=0x24.
//   - One cycle later: if_pc=0x94.
// - Branch coinciding with id_ready=0 and a full FIFO: the flush still occurs and the PC loads the target.
// - Reset mid-stream with pc=0x40 and count=2:
//   - next cycle pc=RESET_PC, if_valid=0;
//   - fetch resumes at word 0.
// - Wrap: branch to 0xFFFF_FFFC, then two pops give if_pc=0x0000_0000 and then 0x0000_0004.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
// Contents: INST_W, RESET_PC_DEFAULT, NOP_INST, fetch_entry_t (one prefetch FIFO slot).
package instruction_fetch_unit_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc_plus4;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory, redirect and decode-side signals of the fetch unit
// master: fetch unit side (drives imem_adr, if_*, fifo_count)
// slave : environment side (drives imem_inst, branch_*, id_ready)
interface instruction_fetch_unit_if #(
  parameter int FIFO_DEPTH = 2
) ();
  import instruction_fetch_unit_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       imem_adr;
  logic [INST_W-1:0] imem_inst;
  logic              branch_taken;
  logic [31:0]       branch_addr;
  logic              id_ready;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [31:0]       if_pc;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output imem_adr,
    input  imem_inst,
    input  branch_taken,
    input  branch_addr,
    input  id_ready,
    output if_valid,
    output if_inst,
    output if_pc,
    output fifo_count
  );

  modport slave (
    input  imem_adr,
    output imem_inst,
    output branch_taken,
    output branch_addr,
    output id_ready,
    input  if_valid,
    input  if_inst,
    input  if_pc,
    input  fifo_count
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - synchronous prefetch FIFO with flush and registered head
// Ports: clk, rst (sync, active-high), flush, push, wr_data, pop,
//        head_valid/head_data (zero when empty), count (occupancy, one bit wider than pointers).
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               wr_data,
  input  logic                       pop,
  output logic                       head_valid,
  output fetch_entry_t               head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;

  always_comb begin
    // Pop only when something is there; push when there is room or the pop frees it.
    do_pop  = pop & (count_q != '0);
    do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and prefetcher between instruction memory and decode
// Ports: clk, rst (sync, active-high), bus (instruction_fetch_unit_if.master):
//   imem_adr/imem_inst word-indexed combinational fetch, branch_taken/branch_addr redirect,
//   id_ready/if_valid/if_inst/if_pc decode handshake, fifo_count debug occupancy.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic             head_valid;
  fetch_entry_t     head_data;
  fetch_entry_t     wr_data;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             full;
  logic             push;

  always_comb begin
    pop  = head_valid & bus.id_ready;
    full = (count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still streams at one per cycle.
    push = ~bus.branch_taken & (~full | pop);

    wr_data.pc_plus4 = pc_q + 32'd4;
    wr_data.inst     = bus.imem_inst;

    pc_d = pc_q;
    if (bus.branch_taken) begin
      pc_d = {bus.branch_addr[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.branch_taken),
    .push       (push),
    .wr_data    (wr_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign bus.imem_adr   = {2'b00, pc_q[31:2]};
  assign bus.if_valid   = head_valid;
  assign bus.if_inst    = head_valid ? head_data.inst : NOP_INST;
  assign bus.if_pc      = head_valid ? head_data.pc_plus4 : 32'h0;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit_if #(.FIFO_DEPTH(DEPTH)) bus ();

  instruction_fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_inst = mem_fn(bus.imem_adr);

  // Reference model: queue of {pc+4, inst} and a byte PC.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic b, input logic [31:0] ba, input logic rdy);
    bit do_pop;
    bit is_full;
    if (r) begin
      mpc = RPC;
      mq.delete();
    end else if (b) begin
      mq.delete();
      mpc = ba & 32'hFFFF_FFFC;
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      is_full = (mq.size() == DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (!is_full || do_pop) begin
        mq.push_back({mpc + 32'd4, mem_fn(mpc >> 2)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] h;
    h = (mq.size() > 0) ? mq[0] : 64'h0;
    check_eq("if_valid",   32'(bus.if_valid),   32'(mq.size() > 0));
    check_eq("if_inst",    bus.if_inst,         h[31:0]);
    check_eq("if_pc",      bus.if_pc,           h[63:32]);
    check_eq("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    check_eq("imem_adr",   bus.imem_adr,        mpc >> 2);
  endtask

  task automatic cycle(input logic r, input logic b, input logic [31:0] ba, input logic rdy);
    rst              = r;
    bus.branch_taken = b;
    bus.branch_addr  = ba;
    bus.id_ready     = rdy;
    @(posedge clk);
    model_step(r, b, ba, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    rst              = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'h0;
    bus.id_ready     = 1'b0;
    mpc              = RPC;

    // Reset
    cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h100, 1);
    check_eq("rst_adr",   bus.imem_adr,        32'h0);
    check_eq("rst_valid", 32'(bus.if_valid),   32'h0);
    check_eq("rst_count", 32'(bus.fifo_count), 32'h0);

    // Stream
    cycle(0, 0, 0, 1);
    check_eq("stream_adr1", bus.imem_adr, 32'd1);
    check_eq("stream_pc1",  bus.if_pc,    32'd4);
    cycle(0, 0, 0, 1);
    check_eq("stream_adr2", bus.imem_adr, 32'd2);
    check_eq("stream_pc2",  bus.if_pc,    32'd8);
    cycle(0, 0, 0, 1);
    check_eq("stream_pc3",  bus.if_pc,    32'd12);
    check_eq("stream_vld",  32'(bus.if_valid), 32'h1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check_eq("pre_freeze_adr", bus.imem_adr, 32'd5);

    // Freeze for 5 cycles
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    check_eq("freeze_count", 32'(bus.fifo_count), 32'd2);
    check_eq("freeze_adr",   bus.imem_adr,        32'd6);
    check_eq("freeze_head",  bus.if_pc,           32'h14);
    cycle(0, 0, 0, 1);
    check_eq("release_pc1", bus.if_pc, 32'h18);
    cycle(0, 0, 0, 1);
    check_eq("release_pc2", bus.if_pc, 32'h1C);
    check_eq("release_cnt", 32'(bus.fifo_count), 32'd2);

    // Branch with two entries held
    cycle(0, 1, 32'h93, 1);
    check_eq("br_valid", 32'(bus.if_valid),   32'h0);
    check_eq("br_count", 32'(bus.fifo_count), 32'h0);
    check_eq("br_adr",   bus.imem_adr,        32'h24);
    cycle(0, 0, 0, 1);
    check_eq("br_target_pc", bus.if_pc, 32'h94);

    // Branch during freeze with a full FIFO
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("frz_full", 32'(bus.fifo_count), 32'd2);
    cycle(0, 1, 32'h200, 0);
    check_eq("frz_br_count", 32'(bus.fifo_count), 32'h0);
    check_eq("frz_br_adr",   bus.imem_adr,        32'h80);
    cycle(0, 0, 0, 0);
    check_eq("frz_br_pc", bus.if_pc, 32'h204);

    // Reset mid-stream with pc=0x40, count=2
    cycle(0, 1, 32'h38, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check_eq("mid_adr",   bus.imem_adr,        32'h10);
    check_eq("mid_count", 32'(bus.fifo_count), 32'd2);
    cycle(1, 0, 0, 1);
    check_eq("mid_rst_adr",   bus.imem_adr,      32'h0);
    check_eq("mid_rst_valid", 32'(bus.if_valid), 32'h0);
    cycle(0, 0, 0, 1);
    check_eq("resume_adr", bus.imem_adr, 32'h1);
    check_eq("resume_pc",  bus.if_pc,    32'h4);

    // PC wrap
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    check_eq("wrap_adr", bus.imem_adr, 32'h3FFF_FFFF);
    cycle(0, 0, 0, 1);
    check_eq("wrap_pc0", bus.if_pc, 32'h0000_0000);
    check_eq("wrap_vld", 32'(bus.if_valid), 32'h1);
    cycle(0, 0, 0, 1);
    check_eq("wrap_pc1", bus.if_pc, 32'h0000_0004);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic r, b, rdy;
      logic [31:0] ba;
      r   = ($urandom_range(0, 99) < 2);
      b   = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 65);
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle(r, b, ba, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
